// File: rtl/prf_read_arbiter_if.sv
// Request/bank/response bundle between the PRF read requesters, the banks and prf_read_arbiter.
interface prf_read_arbiter_if #(
  parameter int PRF_RR_COUNT   = 11,
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4,
  parameter int XLEN           = 32
);
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  logic [PRF_RR_COUNT-1:0]                    req_valid_by_rr;
  logic [PRF_RR_COUNT-1:0][LOG_PR_COUNT-1:0]  req_pr_by_rr;
  logic [PRF_RR_COUNT-1:0]                    req_ready_by_rr;
  logic [PRF_BANK_COUNT-1:0]                  bank_read_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]       bank_read_index_by_bank;
  logic [PRF_BANK_COUNT-1:0][XLEN-1:0]        bank_read_data_by_bank;
  logic [PRF_RR_COUNT-1:0]                    rsp_valid_by_rr;
  logic [PRF_RR_COUNT-1:0][XLEN-1:0]          rsp_data_by_rr;

  modport slave (
    input  req_valid_by_rr, req_pr_by_rr, bank_read_data_by_bank,
    output req_ready_by_rr, bank_read_valid_by_bank, bank_read_index_by_bank,
           rsp_valid_by_rr, rsp_data_by_rr
  );

  modport master (
    output req_valid_by_rr, req_pr_by_rr, bank_read_data_by_bank,
    input  req_ready_by_rr, bank_read_valid_by_bank, bank_read_index_by_bank,
           rsp_valid_by_rr, rsp_data_by_rr
  );
endinterface

// File: rtl/prf_read_arbiter.sv
// Per-bank round-robin arbiter for the PRF read ports; data returns to the winner two cycles after grant.
// Define PRF_READ_ARBITER_COALESCE_EN to also grant requesters whose PR matches the bank winner's PR.
module prf_read_arbiter #(
  parameter int PRF_RR_COUNT   = 11,
  parameter int PR_COUNT       = 128,
  parameter int PRF_BANK_COUNT = 4,
  parameter int XLEN           = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  prf_read_arbiter_if.slave     bus
);
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_RR             = $clog2(PRF_RR_COUNT);
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  logic [PRF_RR_COUNT-1:0]           w_grant_by_bank [PRF_BANK_COUNT];
  logic [PRF_RR_COUNT-1:0]           w_rsp_mask_by_bank [PRF_BANK_COUNT];
  logic [PRF_RR_COUNT-1:0]           w_ready;
  logic [PRF_RR_COUNT-1:0]           w_rsp_valid;
  logic [PRF_RR_COUNT-1:0][XLEN-1:0] w_rsp_data;

  for (genvar gi = 0; gi < PRF_BANK_COUNT; gi++) begin : g_bank
    logic [PRF_RR_COUNT-1:0] w_cand;
    logic                    w_win_valid;
    logic [LOG_RR-1:0]       w_win_id;
    logic [LOG_PR_COUNT-1:0] w_win_pr;
    logic [PRF_RR_COUNT-1:0] w_grant;
    logic [LOG_RR-1:0]       r_rr_ptr;
    logic                    r_s1_valid;
    logic [PRF_RR_COUNT-1:0] r_s1_mask;
    logic [ROW_W-1:0]        r_row;
    logic                    r_s2_valid;
    logic [PRF_RR_COUNT-1:0] r_s2_mask;

    always_comb begin
      w_cand = '0;
      for (int r = 0; r < PRF_RR_COUNT; r++) begin
        w_cand[r] = bus.req_valid_by_rr[r] &&
                    (bus.req_pr_by_rr[r][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(gi));
      end
    end

    // Scan from the pointer, wrapping at PRF_RR_COUNT rather than at the next power of two.
    always_comb begin
      int idx;
      w_win_valid = 1'b0;
      w_win_id    = '0;
      w_win_pr    = '0;
      idx         = 0;
      for (int k = 0; k < PRF_RR_COUNT; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= PRF_RR_COUNT) idx = idx - PRF_RR_COUNT;
        if (!w_win_valid && w_cand[idx]) begin
          w_win_valid = 1'b1;
          w_win_id    = LOG_RR'(idx);
          w_win_pr    = bus.req_pr_by_rr[idx];
        end
      end
    end

    always_comb begin
      w_grant = '0;
      for (int r = 0; r < PRF_RR_COUNT; r++) begin
        if (w_win_valid && (LOG_RR'(r) == w_win_id)) w_grant[r] = 1'b1;
`ifdef PRF_READ_ARBITER_COALESCE_EN
        if (w_win_valid && w_cand[r] && (bus.req_pr_by_rr[r] == w_win_pr)) w_grant[r] = 1'b1;
`endif
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_rr_ptr   <= '0;
        r_s1_valid <= 1'b0;
        r_s1_mask  <= '0;
        r_row      <= '0;
        r_s2_valid <= 1'b0;
        r_s2_mask  <= '0;
      end else begin
        if (w_win_valid) begin
          r_rr_ptr <= (w_win_id == LOG_RR'(PRF_RR_COUNT - 1)) ? '0 : w_win_id + 1'b1;
          r_row    <= w_win_pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
        r_s1_valid <= w_win_valid;
        r_s1_mask  <= w_grant;
        r_s2_valid <= r_s1_valid;
        r_s2_mask  <= r_s1_mask;
      end
    end

    assign bus.bank_read_valid_by_bank[gi] = r_s1_valid;
    assign bus.bank_read_index_by_bank[gi] = r_row;
    assign w_grant_by_bank[gi]             = w_grant;
    assign w_rsp_mask_by_bank[gi]          = r_s2_valid ? r_s2_mask : '0;
  end

  always_comb begin
    w_ready = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) w_ready = w_ready | w_grant_by_bank[b];
  end

  // A requester is granted by at most one bank per cycle, so at most one mask bit hits it.
  always_comb begin
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int r = 0; r < PRF_RR_COUNT; r++) begin
        if (w_rsp_mask_by_bank[b][r]) begin
          w_rsp_valid[r] = 1'b1;
          w_rsp_data[r]  = bus.bank_read_data_by_bank[b];
        end
      end
    end
  end

  assign bus.req_ready_by_rr = w_ready;
  assign bus.rsp_valid_by_rr = w_rsp_valid;
  assign bus.rsp_data_by_rr  = w_rsp_data;
endmodule

// File: tb/tb_prf_read_arbiter.sv
// Table-driven cycle vectors for prf_read_arbiter plus a hand-written reset-in-flight sequence.
module tb_prf_read_arbiter;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  prf_read_arbiter_if bus ();
  prf_read_arbiter dut (.CLK(clk), .nRST(nrst), .bus(bus));

  typedef struct {
    logic [10:0]       valid;
    logic [10:0][6:0]  pr;
    logic [3:0][31:0]  bdata;
    logic [10:0]       exp_ready;
    logic [3:0]        exp_bvalid;
    logic [3:0][4:0]   exp_bidx;
    logic [10:0]       exp_rsp_valid;
    logic [10:0][31:0] exp_rsp_data;
  } vec_t;

  vec_t tbl[$];
  vec_t w;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [351:0] act, input logic [351:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle fields are cleared; PRs and the held bank row index carry over.
  task automatic clr();
    w.valid = '0; w.bdata = '0; w.exp_ready = '0; w.exp_bvalid = '0;
    w.exp_rsp_valid = '0; w.exp_rsp_data = '0;
  endtask
  task automatic push();             tbl.push_back(w); endtask
  task automatic rq(input int r, input logic [6:0] pr); w.valid[r] = 1'b1; w.pr[r] = pr; endtask
  task automatic bv(input int b, input logic [4:0] row); w.exp_bvalid[b] = 1'b1; w.exp_bidx[b] = row; endtask
  task automatic rs(input int r, input logic [31:0] d); w.exp_rsp_valid[r] = 1'b1; w.exp_rsp_data[r] = d; endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      bus.req_valid_by_rr        = tbl[i].valid;
      bus.req_pr_by_rr           = tbl[i].pr;
      bus.bank_read_data_by_bank = tbl[i].bdata;
      @(negedge clk);
      chk($sformatf("%s[%0d].ready", tag, i),    352'(bus.req_ready_by_rr),         352'(tbl[i].exp_ready));
      chk($sformatf("%s[%0d].bvalid", tag, i),   352'(bus.bank_read_valid_by_bank), 352'(tbl[i].exp_bvalid));
      chk($sformatf("%s[%0d].bidx", tag, i),     352'(bus.bank_read_index_by_bank), 352'(tbl[i].exp_bidx));
      chk($sformatf("%s[%0d].rsp_valid", tag, i), 352'(bus.rsp_valid_by_rr),        352'(tbl[i].exp_rsp_valid));
      chk($sformatf("%s[%0d].rsp_data", tag, i), 352'(bus.rsp_data_by_rr),          352'(tbl[i].exp_rsp_data));
      $display("%s vec %0d: valid=%h ready=%h bvalid=%h bidx=%h rsp_valid=%h", tag, i,
               tbl[i].valid, bus.req_ready_by_rr, bus.bank_read_valid_by_bank,
               bus.bank_read_index_by_bank, bus.rsp_valid_by_rr);
    end
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0;
    bus.req_valid_by_rr = '0; bus.req_pr_by_rr = '0; bus.bank_read_data_by_bank = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.ready",     352'(bus.req_ready_by_rr),         352'(0));
    chk("reset.bvalid",    352'(bus.bank_read_valid_by_bank), 352'(0));
    chk("reset.bidx",      352'(bus.bank_read_index_by_bank), 352'(0));
    chk("reset.rsp_valid", 352'(bus.rsp_valid_by_rr),         352'(0));
    chk("reset.rsp_data",  352'(bus.rsp_data_by_rr),          352'(0));
    @(posedge clk); #1 nrst = 1'b1;

    w.pr = '0; w.exp_bidx = '0;
    // Single requester: rr3 -> PR 0x15 (bank 1, row 5)
    clr(); rq(3, 7'h15); w.exp_ready[3] = 1'b1; push();
    clr(); bv(1, 5); push();
    clr(); w.bdata[1] = 32'hDEADBEEF; rs(3, 32'hDEADBEEF); push();
    // Round-robin on bank 2: rr0/5/10 hold requests, grants 0,5,10,0
    clr(); rq(0, 7'h02); rq(5, 7'h06); rq(10, 7'h0A); w.exp_ready[0] = 1'b1; push();
    clr(); rq(0, 7'h02); rq(5, 7'h06); rq(10, 7'h0A); w.exp_ready[5] = 1'b1; bv(2, 0); push();
    clr(); rq(0, 7'h02); rq(5, 7'h06); rq(10, 7'h0A); w.exp_ready[10] = 1'b1; bv(2, 1);
           w.bdata[2] = 32'hA0000000; rs(0, 32'hA0000000); push();
    clr(); rq(0, 7'h02); rq(5, 7'h06); rq(10, 7'h0A); w.exp_ready[0] = 1'b1; bv(2, 2);
           w.bdata[2] = 32'hA0000001; rs(5, 32'hA0000001); push();
    clr(); bv(2, 0); w.bdata[2] = 32'hA0000002; rs(10, 32'hA0000002); push();
    clr(); w.bdata[2] = 32'hA0000003; rs(0, 32'hA0000003); push();
    // Bank parallelism: rr0..3 -> PR 0..3
    clr(); for (int r = 0; r < 4; r++) begin rq(r, 7'(r)); w.exp_ready[r] = 1'b1; end push();
    clr(); for (int b = 0; b < 4; b++) bv(b, 0); push();
    clr(); for (int b = 0; b < 4; b++) begin w.bdata[b] = 32'h11110000 + b; rs(b, 32'h11110000 + b); end push();
    // Back-to-back rr4: PR 8 (row 2) then PR 12 (row 3)
    clr(); rq(4, 7'd8);  w.exp_ready[4] = 1'b1; push();
    clr(); rq(4, 7'd12); w.exp_ready[4] = 1'b1; bv(0, 2); push();
    clr(); bv(0, 3); w.bdata[0] = 32'hC0DE0002; rs(4, 32'hC0DE0002); push();
    clr(); w.bdata[0] = 32'hC0DE0003; rs(4, 32'hC0DE0003); push();
    run_tbl("A");

    // Reset mid-flight: grant rr5 on bank 3, reset the next cycle, no response may appear
    @(posedge clk); #1;
    bus.req_valid_by_rr = 11'(1) << 5; bus.req_pr_by_rr[5] = 7'h03; bus.bank_read_data_by_bank = '0;
    @(negedge clk);
    chk("rst.grant", 352'(bus.req_ready_by_rr), 352'(11'(1) << 5));
    @(posedge clk); #1; bus.req_valid_by_rr = '0; nrst = 1'b0;
    @(negedge clk);
    chk("rst.n1.bvalid",    352'(bus.bank_read_valid_by_bank), 352'(0));
    chk("rst.n1.rsp_valid", 352'(bus.rsp_valid_by_rr),         352'(0));
    @(posedge clk); #1; bus.bank_read_data_by_bank[3] = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rst.n2.rsp_valid", 352'(bus.rsp_valid_by_rr), 352'(0));
    chk("rst.n2.rsp_data",  352'(bus.rsp_data_by_rr),  352'(0));
    @(posedge clk); #1; nrst = 1'b1;
    @(negedge clk);
    chk("rst.n3.rsp_valid", 352'(bus.rsp_valid_by_rr),         352'(0));
    chk("rst.n3.bvalid",    352'(bus.bank_read_valid_by_bank), 352'(0));

    w.exp_bidx = '0;
    // Pointer of bank 3 must be back at 0: rr1 wins over rr7
    clr(); rq(1, 7'h07); rq(7, 7'h0B); w.exp_ready[1] = 1'b1; push();
    clr(); rq(7, 7'h0B); w.exp_ready[7] = 1'b1; bv(3, 1); push();
    clr(); bv(3, 2); w.bdata[3] = 32'hE1E1E1E1; rs(1, 32'hE1E1E1E1); push();
    clr(); w.bdata[3] = 32'hE2E2E2E2; rs(7, 32'hE2E2E2E2); push();
    // Same-PR contention: rr1 and rr7 -> PR 0x40 (bank 0, row 16), ptr 0
    clr(); rq(1, 7'h40); rq(7, 7'h40); w.exp_ready[1] = 1'b1;
`ifdef PRF_READ_ARBITER_COALESCE_EN
    w.exp_ready[7] = 1'b1; push();
    clr(); bv(0, 16); push();
    clr(); w.bdata[0] = 32'hF0F0F0F0; rs(1, 32'hF0F0F0F0); rs(7, 32'hF0F0F0F0); push();
    clr(); w.bdata[0] = 32'hF1F1F1F1; push();
`else
    push();
    clr(); rq(7, 7'h40); w.exp_ready[7] = 1'b1; bv(0, 16); push();
    clr(); bv(0, 16); w.bdata[0] = 32'hF0F0F0F0; rs(1, 32'hF0F0F0F0); push();
    clr(); w.bdata[0] = 32'hF1F1F1F1; rs(7, 32'hF1F1F1F1); push();
`endif
    run_tbl("B");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
